// File: rtl/dmem_pipelined.sv
module dmem_pipelined #(
  parameter int MEM_BYTES        = 4096,
  parameter int READ_LATENCY     = 1,
  parameter int ALLOW_MISALIGNED = 1,
  parameter     INIT_FILE        = "Memory.txt"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  output logic        Ready,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic        RspValid,
  output logic [31:0] DataRd,
  output logic        Fault
);
  localparam int AB    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int IW    = AB - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    PIPE  = 2'd3
  } state_t;

  logic [31:0]   mem [WORDS];

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AB-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [2:0]    ctrl_q;
  logic          fault_q;
  logic          split_q;
  logic [31:0]   rd_q, rd_d;

  logic [2:0]  size_in;
  logic [32:0] last_byte;
  logic        split_in, fault_in, accept;

  always_comb begin
    case (DMCtrl[1:0])
      2'b00:   size_in = 3'd1;
      2'b01:   size_in = 3'd2;
      default: size_in = 3'd4;
    endcase
  end

  assign last_byte = {1'b0, Address} + {30'b0, size_in} - 33'd1;
  assign split_in  = ({1'b0, Address[1:0]} + size_in - 3'd1) > 3'd3;
  // Range check on the last byte covers both overrun and nonzero high bits.
  assign fault_in  = (DMCtrl == 3'b011) || (DMCtrl == 3'b110) || (DMCtrl == 3'b111)
                   || (DMWr && DMCtrl[2])
                   || (last_byte >= 33'(MEM_BYTES))
                   || (split_in && (ALLOW_MISALIGNED == 0));

  logic [2:0]    acc_size;
  logic [IW-1:0] idx0, cur_idx;
  logic [31:0]   rword, wbytes;
  logic [3:0]    be;
  logic [2:0]    lane;
  logic          in_beat, last_beat, rsp, mem_we;

  always_comb begin
    case (ctrl_q[1:0])
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  end

  assign idx0    = addr_q[AB-1:2];
  assign cur_idx = (state_q == BEAT1) ? IW'(idx0 + 1'b1) : idx0;
  assign rword   = mem[cur_idx];
  assign in_beat = (state_q == BEAT0) || (state_q == BEAT1);

  // Access byte k lives at lane (offset + k); lanes 4..6 belong to BEAT1.
  always_comb begin
    rd_d   = (state_q == BEAT0) ? '0 : rd_q;
    be     = '0;
    wbytes = '0;
    lane   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      lane = {1'b0, addr_q[1:0]} + 3'(k);
      if ((3'(k) < acc_size) &&
          (((state_q == BEAT0) && !lane[2]) || ((state_q == BEAT1) && lane[2]))) begin
        rd_d[8*k +: 8]           = rword[8*lane[1:0] +: 8];
        be[lane[1:0]]            = 1'b1;
        wbytes[8*lane[1:0] +: 8] = wdata_q[8*k +: 8];
      end
    end
  end

  assign mem_we = in_beat && wr_q && !fault_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[l]) mem[cur_idx][8*l +: 8] <= wbytes[8*l +: 8];
      end
    end
  end

  // Response is raised in the final cycle so the closing edge can accept anew.
  assign last_beat = ((state_q == BEAT0) && !split_q) || (state_q == BEAT1);
  assign rsp       = (READ_LATENCY == 1) ? last_beat
                   : ((state_q == PIPE) && (cnt_q == 2'(READ_LATENCY - 2)));
  assign Ready     = (state_q == IDLE) || rsp;
  assign accept    = Req && Ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BEAT0: begin
        if (split_q) begin
          state_d = BEAT1;
        end else if (READ_LATENCY > 1) begin
          state_d = PIPE;
          cnt_d   = '0;
        end
      end
      BEAT1: begin
        if (READ_LATENCY > 1) begin
          state_d = PIPE;
          cnt_d   = '0;
        end
      end
      PIPE:    cnt_d = cnt_q + 2'd1;
      default: ;
    endcase
    if (rsp)    state_d = IDLE;
    if (accept) state_d = BEAT0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      fault_q <= 1'b0;
      split_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_beat) rd_q <= rd_d;
      if (accept) begin
        addr_q  <= Address[AB-1:0];
        wdata_q <= DataWr;
        wr_q    <= DMWr;
        ctrl_q  <= DMCtrl;
        fault_q <= fault_in;
        split_q <= split_in && !fault_in;
      end
    end
  end

  logic [31:0] ext;
  always_comb begin
    case (ctrl_q)
      3'b000:  ext = {{24{rd_d[7]}}, rd_d[7:0]};
      3'b001:  ext = {{16{rd_d[15]}}, rd_d[15:0]};
      3'b010:  ext = rd_d;
      3'b100:  ext = {24'b0, rd_d[7:0]};
      3'b101:  ext = {16'b0, rd_d[15:0]};
      default: ext = '0;
    endcase
  end

  assign RspValid = rsp;
  assign Fault    = rsp && fault_q;
  assign DataRd   = (rsp && !fault_q && !wr_q) ? ext : '0;

endmodule

// File: tb/tb_dmem_pipelined.sv
module tb_dmem_pipelined;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdat = '0;
    logic        wr = 1'b0;
    logic [2:0]  ctl = '0;
    logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2, ft0, ft1, ft2;
    logic [31:0] rd0, rd1, rd2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_pipelined #(.MEM_BYTES(4096), .READ_LATENCY(1), .ALLOW_MISALIGNED(1)) u0 (
        .clk(clk), .rst_n(rst_n), .Req(req0), .Ready(rdy0), .Address(addr),
        .DataWr(wdat), .DMWr(wr), .DMCtrl(ctl), .RspValid(rv0), .DataRd(rd0), .Fault(ft0));
    dmem_pipelined #(.MEM_BYTES(4096), .READ_LATENCY(3), .ALLOW_MISALIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .Req(req1), .Ready(rdy1), .Address(addr),
        .DataWr(wdat), .DMWr(wr), .DMCtrl(ctl), .RspValid(rv1), .DataRd(rd1), .Fault(ft1));
    dmem_pipelined #(.MEM_BYTES(4096), .READ_LATENCY(1), .ALLOW_MISALIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .Req(req2), .Ready(rdy2), .Address(addr),
        .DataWr(wdat), .DMWr(wr), .DMCtrl(ctl), .RspValid(rv2), .DataRd(rd2), .Fault(ft2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int d);
        case (d)
            0: return rdy0;
            1: return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic rv_of(input int d);
        case (d)
            0: return rv0;
            1: return rv1;
            default: return rv2;
        endcase
    endfunction

    task automatic set_req(input int d, input logic v);
        case (d)
            0: req0 = v;
            1: req1 = v;
            default: req2 = v;
        endcase
    endtask

    // One request on DUT d; lat counts cycles after the accept edge until RspValid.
    task automatic txn(input int d, input logic w, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] dat, output logic [31:0] rdat, output logic flt,
                       output int lat);
        int n;
        @(negedge clk);
        addr = a; wdat = dat; wr = w; ctl = c;
        set_req(d, 1'b1);
        n = 0;
        while (!rdy_of(d) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_of(d)) begin
            chk("accept_timeout", 32'd0, 32'd1);
            set_req(d, 1'b0);
            rdat = '0; flt = 1'b0; lat = 99;
            return;
        end
        @(negedge clk);
        set_req(d, 1'b0);
        lat = 1;
        while (!rv_of(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        case (d)
            0: begin rdat = rd0; flt = ft0; end
            1: begin rdat = rd1; flt = ft1; end
            default: begin rdat = rd2; flt = ft2; end
        endcase
    endtask

    logic [31:0] r;
    logic        f;
    int          lat;

    initial begin
        // Reset state
        #3;
        chk("rst_rv", {31'b0, rv0}, 32'd0);
        chk("rst_rd", rd0, 32'd0);
        chk("rst_fault", {31'b0, ft0}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", {31'b0, rdy0}, 32'd1);

        // Aligned store/load, READ_LATENCY=1
        txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, r, f, lat);
        chk("st_w_lat", lat, 1);
        chk("st_w_data0", r, 32'd0);
        txn(0, 0, 3'b010, 32'h10, 32'h0, r, f, lat);
        chk("ld_w_lat", lat, 1);
        chk("ld_w", r, 32'hDEADBEEF);
        chk("ld_w_fault", {31'b0, f}, 32'd0);
        txn(0, 0, 3'b100, 32'h13, 32'h0, r, f, lat);
        chk("ld_bu13", r, 32'h000000DE);
        txn(0, 0, 3'b000, 32'h10, 32'h0, r, f, lat);
        chk("ld_b10", r, 32'hFFFFFFEF);
        txn(0, 0, 3'b101, 32'h12, 32'h0, r, f, lat);
        chk("ld_hu12", r, 32'h0000DEAD);
        txn(0, 0, 3'b001, 32'h12, 32'h0, r, f, lat);
        chk("ld_h12", r, 32'hFFFFDEAD);

        // Misaligned store across words 0x1C/0x20
        txn(0, 1, 3'b010, 32'h1C, 32'hCAFEF00D, r, f, lat);
        txn(0, 1, 3'b010, 32'h1E, 32'h11223344, r, f, lat);
        chk("split_st_lat", lat, 2);
        chk("split_st_fault", {31'b0, f}, 32'd0);
        txn(0, 0, 3'b010, 32'h1C, 32'h0, r, f, lat);
        chk("split_ld_1c", r, 32'h3344F00D);
        txn(0, 0, 3'b001, 32'h20, 32'h0, r, f, lat);
        chk("split_ld_h20", r, 32'h00001122);
        txn(0, 0, 3'b010, 32'h1E, 32'h0, r, f, lat);
        chk("split_ld_lat", lat, 2);
        chk("split_ld_w1e", r, 32'h11223344);

        // Misaligned disallowed
        txn(2, 1, 3'b010, 32'h1C, 32'hCAFEF00D, r, f, lat);
        txn(2, 1, 3'b010, 32'h20, 32'h55667788, r, f, lat);
        txn(2, 1, 3'b010, 32'h1E, 32'h11223344, r, f, lat);
        chk("noma_fault", {31'b0, f}, 32'd1);
        chk("noma_lat", lat, 1);
        txn(2, 0, 3'b010, 32'h1C, 32'h0, r, f, lat);
        chk("noma_1c", r, 32'hCAFEF00D);
        txn(2, 0, 3'b010, 32'h20, 32'h0, r, f, lat);
        chk("noma_20", r, 32'h55667788);

        // Faults
        txn(0, 1, 3'b100, 32'h10, 32'h00000000, r, f, lat);
        chk("flt_st_bu", {31'b0, f}, 32'd1);
        txn(0, 0, 3'b100, 32'h10, 32'h0, r, f, lat);
        chk("flt_st_bu_mem", r, 32'h000000EF);
        txn(0, 0, 3'b010, 32'd4094, 32'h0, r, f, lat);
        chk("flt_range", {31'b0, f}, 32'd1);
        chk("flt_range_rd", r, 32'd0);
        chk("flt_range_lat", lat, 1);
        txn(0, 0, 3'b111, 32'h10, 32'h0, r, f, lat);
        chk("flt_ctl111", {31'b0, f}, 32'd1);
        txn(0, 0, 3'b000, 32'h0001_0010, 32'h0, r, f, lat);
        chk("flt_highbits", {31'b0, f}, 32'd1);

        // READ_LATENCY=3, back-to-back with Req held
        txn(1, 1, 3'b010, 32'h40, 32'h01020304, r, f, lat);
        chk("l3_st_lat", lat, 3);
        txn(1, 1, 3'b010, 32'h44, 32'hA5A55A5A, r, f, lat);
        @(negedge clk);
        addr = 32'h40; wr = 1'b0; ctl = 3'b010; req1 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk("b2b_rv", {31'b0, rv1}, {31'b0, (n == 3 || n == 6)});
            chk("b2b_rdy", {31'b0, rdy1}, {31'b0, (n == 3 || n == 6)});
            if (n == 3) begin
                chk("b2b_rd0", rd1, 32'h01020304);
                addr = 32'h44;
            end
            if (n == 6) begin
                chk("b2b_rd1", rd1, 32'hA5A55A5A);
                req1 = 1'b0;
            end
        end

        // Reset during BEAT1 of a split store
        txn(0, 1, 3'b010, 32'h30, 32'hAAAAAAAA, r, f, lat);
        txn(0, 1, 3'b010, 32'h34, 32'hBBBBBBBB, r, f, lat);
        @(negedge clk);
        addr = 32'h32; wdat = 32'h11223344; wr = 1'b1; ctl = 3'b010; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        chk("beat0_ready", {31'b0, rdy0}, 32'd0);
        @(negedge clk);
        chk("beat1_rv", {31'b0, rv0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rv", {31'b0, rv0}, 32'd0);
        chk("mid_rst_rd", rd0, 32'd0);
        chk("mid_rst_fault", {31'b0, ft0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rst_ready", {31'b0, rdy0}, 32'd1);
        txn(0, 0, 3'b010, 32'h30, 32'h0, r, f, lat);
        chk("mid_rst_w30", r, 32'h3344AAAA);
        txn(0, 0, 3'b010, 32'h34, 32'h0, r, f, lat);
        chk("mid_rst_w34", r, 32'hBBBBBBBB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
